axi_mem_ctrl: RTL and testbench

//  Memory stage directly downstream of the AXI slave. Consumes the per-cycle memory command (maddr/mdata/mwstrb/mread/mwrite),

---
 rtl/axi_mem_pkg.sv | 23 ++
 rtl/axi_mem_array.sv | 49 ++++
 rtl/axi_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_axi_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg
//  Types and constants shared by the memory stage and the AXI slave.
//  Contents:
//   mem_state_t   controller state (INIT zero-fill, RUN normal operation)
//   BURST_*       AXI burst type encodings (fixed/incr/wrap)
//   offs_w()      number of byte-offset bits in an address for a given data width
package axi_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Byte-offset bits below the word index; data_w is a multiple of 8.
    function automatic int offs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array
//  Word array built from DATA_W/8 independent byte-lane RAMs. One write port
//  with per-lane enables, one synchronous read port whose output register
//  holds its value when re_i is low. A read and a write to the same word in
//  the same cycle return the old contents (merging is done by the caller).
//  Ports:
//   aclk     in   clock
//   we_i     in   per-lane write enables
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read word index
//   rdata_o  out  registered read data
module axi_mem_array #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic                  aclk,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [MEM_AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [MEM_AW-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int NUM_LANES = DATA_W / 8;
    localparam int DEPTH     = 1 << MEM_AW;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge aclk) begin
                if (we_i[gi]) begin
                    lane_mem[waddr_i] <= wdata_i[8*gi +: 8];
                end
                if (re_i) begin
                    rdata_q <= lane_mem[raddr_i];
                end
            end

            assign rdata_o[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/axi_mem_ctrl.sv
// axi_mem_ctrl
//  Memory stage downstream of the AXI slave. Executes one read and/or write
//  command per enabled cycle against a byte-strobed word array, returns read
//  data one cycle later, zero-fills the array after reset and flags
//  out-of-range or during-init commands.
//  Ports:
//   aclk, aresetn   clock, asynchronous active-low reset (release is expected
//                   to be synchronised to aclk upstream)
//   maddr/mdata/mwstrb/mread/mwrite   per-cycle memory command
//   gclken          0 freezes everything; commands on such cycles are lost
//   sdata           read data, valid the cycle after a read, held otherwise
//   init_done       1 once the zero-fill has finished
//   err_oor/err_addr  sticky error flag and address of the first bad command
//   rd_cnt/wr_cnt   saturating counts of completed in-range reads/writes
module axi_mem_ctrl
    import axi_mem_pkg::*;
#(
    parameter int                ADDR_W   = 26,
    parameter int                DATA_W   = 32,
    parameter int                MEM_AW   = 10,
    parameter logic [DATA_W-1:0] OOR_WORD = 32'hDEAD_BEEF,
    parameter int                CNT_W    = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     maddr,
    input  logic [DATA_W-1:0]     mdata,
    input  logic [DATA_W/8-1:0]   mwstrb,
    input  logic                  mread,
    input  logic                  mwrite,
    input  logic                  gclken,
    output logic [DATA_W-1:0]     sdata,
    output logic                  init_done,
    output logic                  err_oor,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam int NUM_LANES = DATA_W / 8;
    localparam int OFFS_W    = offs_w(DATA_W);

    mem_state_t              state_q, state_d;
    logic [MEM_AW-1:0]       fill_q, fill_d;
    logic                    init_done_q, init_done_d;
    logic                    err_oor_q, err_oor_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;

    // Read-result shaping: the array port returns the pre-write word, so the
    // lanes written in the same cycle as the read are replayed from here.
    // Reset value (all lanes bypassed, data 0) makes sdata read 0 from reset.
    logic                    oor_q, oor_d;
    logic [NUM_LANES-1:0]    byp_strb_q, byp_strb_d;
    logic [DATA_W-1:0]       byp_data_q, byp_data_d;

    logic [MEM_AW-1:0]       word_idx;
    logic                    in_range;

    logic [NUM_LANES-1:0]    arr_we;
    logic [MEM_AW-1:0]       arr_waddr;
    logic [DATA_W-1:0]       arr_wdata;
    logic                    arr_re;
    logic [DATA_W-1:0]       arr_rdata;

    assign word_idx = maddr[OFFS_W+MEM_AW-1:OFFS_W];
    assign in_range = (maddr[ADDR_W-1:OFFS_W+MEM_AW] == '0);

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        init_done_d = init_done_q;
        err_oor_d   = err_oor_q;
        err_addr_d  = err_addr_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        oor_d       = oor_q;
        byp_strb_d  = byp_strb_q;
        byp_data_d  = byp_data_q;
        arr_we      = '0;
        arr_waddr   = word_idx;
        arr_wdata   = mdata;
        arr_re      = 1'b0;

        if (gclken) begin
            // init_done trails the INIT->RUN transition by one edge.
            init_done_d = (state_q == RUN);

            case (state_q)
                INIT: begin
                    arr_we    = '1;
                    arr_waddr = fill_q;
                    arr_wdata = '0;
                    fill_d    = fill_q + MEM_AW'(1);
                    if (fill_q == '1) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (mwrite && in_range) begin
                        arr_we = mwstrb;
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        end
                    end
                    if (mread) begin
                        oor_d      = !in_range;
                        byp_strb_d = (mwrite && in_range) ? mwstrb : '0;
                        byp_data_d = mdata;
                        if (in_range) begin
                            arr_re = 1'b1;
                            if (rd_cnt_q != '1) begin
                                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase

            // Only the first offending command is recorded.
            if ((mread || mwrite) && (state_q == INIT || !in_range) && !err_oor_q) begin
                err_oor_d  = 1'b1;
                err_addr_d = maddr;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= INIT;
            fill_q      <= '0;
            init_done_q <= 1'b0;
            err_oor_q   <= 1'b0;
            err_addr_q  <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            oor_q       <= 1'b0;
            byp_strb_q  <= '1;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            init_done_q <= init_done_d;
            err_oor_q   <= err_oor_d;
            err_addr_q  <= err_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            oor_q       <= oor_d;
            byp_strb_q  <= byp_strb_d;
            byp_data_q  <= byp_data_d;
        end
    end

    axi_mem_array #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_array (
        .aclk    (aclk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (word_idx),
        .rdata_o (arr_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_sdata
            assign sdata[8*gi +: 8] = oor_q         ? OOR_WORD[8*gi +: 8]   :
                                      byp_strb_q[gi] ? byp_data_q[8*gi +: 8] :
                                                       arr_rdata[8*gi +: 8];
        end
    endgenerate

    assign init_done = init_done_q;
    assign err_oor   = err_oor_q;
    assign err_addr  = err_addr_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_axi_mem_ctrl.sv
// tb_axi_mem_ctrl
//  Directed bench for axi_mem_ctrl (MEM_AW=4, 16 words). A word-level model
//  tracks the expected outputs and is compared with the DUT every cycle;
//  directed steps additionally pin hand-computed values.
module tb_axi_mem_ctrl;
    import axi_mem_pkg::*;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W-1:0] maddr   = '0;
    logic [DATA_W-1:0] mdata   = '0;
    logic [3:0]        mwstrb  = '0;
    logic              mread   = 1'b0;
    logic              mwrite  = 1'b0;
    logic              gclken  = 1'b1;

    logic [DATA_W-1:0] sdata;
    logic              init_done;
    logic              err_oor;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    axi_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_AW   (MEM_AW),
        .OOR_WORD (32'hDEAD_BEEF),
        .CNT_W    (CNT_W)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .maddr     (maddr),
        .mdata     (mdata),
        .mwstrb    (mwstrb),
        .mread     (mread),
        .mwrite    (mwrite),
        .gclken    (gclken),
        .sdata     (sdata),
        .init_done (init_done),
        .err_oor   (err_oor),
        .err_addr  (err_addr),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]       m_mem [DEPTH];
    int                m_edges = 0;      // enabled edges since reset, capped
    logic [31:0]       m_sdata = '0;
    bit                m_err   = 1'b0;
    logic [ADDR_W-1:0] m_eaddr = '0;
    int                m_rd    = 0;
    int                m_wr    = 0;

    always @(posedge aclk or negedge aresetn) begin : model
        bit busy;
        bit in_rng;
        int idx;
        if (!aresetn) begin
            m_edges = 0;
            m_sdata = '0;
            m_err   = 1'b0;
            m_eaddr = '0;
            m_rd    = 0;
            m_wr    = 0;
            // The zero-fill completes before any command can execute.
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (gclken) begin
            busy   = (m_edges < DEPTH);
            in_rng = ((maddr >> (2 + MEM_AW)) == 0);
            idx    = int'(maddr >> 2) % DEPTH;
            if (m_edges < DEPTH + 1) m_edges++;
            if ((mread || mwrite) && (busy || !in_rng) && !m_err) begin
                m_err   = 1'b1;
                m_eaddr = maddr;
            end
            if (!busy && in_rng) begin
                if (mwrite) begin
                    for (int i = 0; i < 4; i++)
                        if (mwstrb[i]) m_mem[idx][8*i +: 8] = mdata[8*i +: 8];
                    if (m_wr < 65535) m_wr++;
                end
                if (mread) begin
                    m_sdata = m_mem[idx];
                    if (m_rd < 65535) m_rd++;
                end
            end else if (!busy && mread) begin
                m_sdata = 32'hDEAD_BEEF;
            end
        end
    end

    always @(posedge aclk) begin : compare
        #3;
        if (chk_en) begin
            chk("sdata",     sdata,     m_sdata);
            chk("init_done", {31'b0, init_done}, {31'b0, (m_edges == DEPTH + 1)});
            chk("err_oor",   {31'b0, err_oor},   {31'b0, m_err});
            chk("err_addr",  {6'b0, err_addr},   {6'b0, m_eaddr});
            chk("rd_cnt",    {16'b0, rd_cnt},    m_rd);
            chk("wr_cnt",    {16'b0, wr_cnt},    m_wr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cmd(input bit g, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        @(negedge aclk);
        gclken = g; mread = rd; mwrite = wr; maddr = a; mdata = d; mwstrb = s;
        @(posedge aclk);
        #4;
        mread = 1'b0; mwrite = 1'b0; gclken = 1'b1;
        $display("txn g=%0b rd=%0b wr=%0b addr=%h data=%h strb=%b -> sdata=%h err=%0b rd_cnt=%0d wr_cnt=%0d",
                 g, rd, wr, a, d, s, sdata, err_oor, rd_cnt, wr_cnt);
    endtask

    task automatic wait_init(input int exp_edges);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(posedge aclk);
            #4;
            n++;
        end
        chk("init_latency", n, exp_edges);
    endtask

    task automatic assert_reset();
        @(negedge aclk);
        aresetn = 1'b0; gclken = 1'b1; mread = 1'b0; mwrite = 1'b0;
        @(negedge aclk);
        chk("rst_sdata",     sdata, 32'h0);
        chk("rst_init_done", {31'b0, init_done}, 32'h0);
        chk("rst_err_oor",   {31'b0, err_oor},   32'h0);
        chk("rst_err_addr",  {6'b0, err_addr},   32'h0);
        chk("rst_rd_cnt",    {16'b0, rd_cnt},    32'h0);
        chk("rst_wr_cnt",    {16'b0, wr_cnt},    32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [ADDR_W-1:0] a;

        // 1: reset, zero-fill of 16 words, every word reads 0.
        aresetn = 1'b0;
        @(negedge aclk);
        chk_en = 1'b1;
        assert_reset();
        aresetn = 1'b1;
        wait_init(17);
        for (int w = 0; w < DEPTH; w++) begin
            do_cmd(1, 1, 0, ADDR_W'(w * 4), 32'h0, 4'h0);
            chk("init_zero", sdata, 32'h0);
        end
        chk("rd_after_scan", {16'b0, rd_cnt}, 32'd16);

        // Fresh start so counters begin at zero.
        assert_reset();
        aresetn = 1'b1;
        wait_init(17);

        // 3: same-cycle read+write, write-first merge over a zero word.
        do_cmd(1, 1, 1, 26'h4, 32'hCAFE_F00D, 4'b1100);
        chk("rw_merge", sdata, 32'hCAFE_0000);
        chk("rw_rd_cnt", {16'b0, rd_cnt}, 32'd1);
        chk("rw_wr_cnt", {16'b0, wr_cnt}, 32'd1);

        // 2: full write then partial-lane write, read back.
        do_cmd(1, 0, 1, 26'h8, 32'h1122_3344, 4'hF);
        do_cmd(1, 0, 1, 26'h8, 32'hAABB_CCDD, 4'b0101);
        do_cmd(1, 1, 0, 26'h8, 32'h0, 4'h0);
        chk("strb_merge", sdata, 32'h11BB_33DD);
        chk("strb_wr_cnt", {16'b0, wr_cnt}, 32'd3);

        // 5b: gclken=0 in RUN drops the command and freezes sdata/counters.
        do_cmd(0, 1, 1, 26'h8, 32'hFFFF_FFFF, 4'hF);
        chk("gate_sdata", sdata, 32'h11BB_33DD);
        chk("gate_rd_cnt", {16'b0, rd_cnt}, 32'd2);
        chk("gate_wr_cnt", {16'b0, wr_cnt}, 32'd3);
        do_cmd(1, 1, 0, 26'h4, 32'h0, 4'h0);
        chk("reread_4", sdata, 32'hCAFE_0000);
        do_cmd(1, 1, 0, 26'h8, 32'h0, 4'h0);
        chk("gate_array", sdata, 32'h11BB_33DD);

        // 4: out-of-range read, then a second bad access.
        do_cmd(1, 1, 0, 26'h40, 32'h0, 4'h0);
        chk("oor_sdata",   sdata, 32'hDEAD_BEEF);
        chk("oor_flag",    {31'b0, err_oor}, 32'h1);
        chk("oor_addr",    {6'b0, err_addr}, 32'h40);
        chk("oor_rd_cnt",  {16'b0, rd_cnt},  32'd4);
        do_cmd(1, 0, 1, 26'h80, 32'h1234_5678, 4'hF);
        chk("oor_addr_kept", {6'b0, err_addr}, 32'h40);
        chk("oor_wr_cnt",    {16'b0, wr_cnt},  32'd3);
        chk("oor_sdata_hold", sdata, 32'hDEAD_BEEF);
        do_cmd(1, 1, 0, 26'h0, 32'h0, 4'h0);
        chk("oor_no_alias", sdata, 32'h0);

        // 6: incrementing burst interrupted by reset.
        a = 26'h10;
        for (int b = 0; b < 4; b++) begin
            do_cmd(1, 0, 1, a, 32'h0100_0000 * (b + 1), 4'hF);
            if (BURST_INCR == 2'b01) a = a + 26'd4;
        end
        do_cmd(1, 1, 0, 26'h14, 32'h0, 4'h0);
        chk("burst_beat1", sdata, 32'h0200_0000);
        assert_reset();
        aresetn = 1'b1;
        gclken  = 1'b0;
        // 5a: command with gclken=0 during INIT is lost without an error.
        do_cmd(0, 0, 1, 26'h24, 32'h5555_5555, 4'hF);
        chk("init_gated_err", {31'b0, err_oor}, 32'h0);
        // Enabled commands during INIT are dropped but flagged.
        do_cmd(1, 0, 1, 26'h20, 32'h7777_7777, 4'hF);
        chk("init_err",      {31'b0, err_oor}, 32'h1);
        chk("init_err_addr", {6'b0, err_addr}, 32'h20);
        do_cmd(1, 1, 0, 26'h10, 32'h0, 4'h0);
        chk("init_rd_drop",  sdata, 32'h0);
        chk("init_rd_cnt",   {16'b0, rd_cnt}, 32'h0);
        chk("init_addr_kept", {6'b0, err_addr}, 32'h20);
        wait_init(15);
        for (int w = 4; w < 8; w++) begin
            do_cmd(1, 1, 0, ADDR_W'(w * 4), 32'h0, 4'h0);
            chk("post_rst_zero", sdata, 32'h0);
        end
        do_cmd(1, 1, 0, 26'h20, 32'h0, 4'h0);
        chk("init_wr_dropped", sdata, 32'h0);

        repeat (2) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
